cu_read_command_arbiter: RTL and testbench
==========================================

Name: cu_read_command_arbiter

Overview:
- Shares one read command buffer among NUM_REQUESTERS read engine controls; each engine offers one CommandBufferLine per cycle.
- Grants at most one command per cycle, round-robin, and forwards it registered to the read command buffer.
- Throttles each requester with a per-requester outstanding-read counter, released by read responses.
- Sits between the CU read engines and the CU command buffer arbiter.

Parameters:
- NUM_REQUESTERS, 4, number of read engines sharing the buffer (2..8).
- MAX_OUTSTANDING, 16, maximum un-responded read commands per requester.
- CU_ID_BASE, DATA_READ_CONTROL_ID, cu_id of requester 0; requester i owns cu_id CU_ID_BASE+i.

Ports:
- clock  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enabled_in  in  1  global enable; registered once internally before use.
- command_in  in  NUM_REQUESTERS x CommandBufferLine  per-requester command; .valid is the request.
- command_ready_out  in->out  NUM_REQUESTERS  grant; a command transfers in the cycle command_in[i].valid && command_ready_out[i].
- read_command_buffer_status  in  BufferStatus  downstream buffer status; .alfull blocks grants.
- read_response_in  in  ResponseBufferLine  read responses; .valid and .cmd.cu_id select the requester.
- command_out  out  CommandBufferLine  granted command, registered.
- outstanding_total_out  out  clog2(NUM_REQUESTERS*MAX_OUTSTANDING+1)  sum of all per-requester counters, registered.
- idle_out  out  1  high when all counters are 0 and command_out.valid is 0.
- response_error_out  out  1  sticky; set on a response for an unknown cu_id or for a requester whose counter is 0.

Behaviour:
- Reset, one cycle with rst=1 at the clock edge:
  - command_out=0, all counters=0, rr_pointer=0, enabled=0.
  - outstanding_total_out=0, response_error_out=0, idle_out=1.
  - Reset mid-operation drops any in-flight grant. Counts for commands already in the buffer are lost by design.
- Eligibility, combinational from registered state:
  - elig[i] = command_in[i].valid && counter[i] < MAX_OUTSTANDING && enabled && ~read_command_buffer_status.alfull.
- Arbitration:
  - Search from rr_pointer upward, wrapping modulo NUM_REQUESTERS. The first eligible index g is granted.
  - command_ready_out[g]=1 combinationally; all other ready bits are 0. At most one bit is ever set.
  - On a grant: command_out <= command_in[g] with valid=1, and rr_pointer <= (g+1) mod NUM_REQUESTERS.
  - No grant: command_out <= 0 (valid=0); rr_pointer holds.
- Latency: 1 cycle from handshake to command_out.valid. Throughput is 1 command per cycle.
- Response handling:
  - On read_response_in.valid, idx = cu_id - CU_ID_BASE.
  - If idx < NUM_REQUESTERS and counter[idx] > 0, then counter[idx] decrements.
  - Otherwise set response_error_out and change no counter.
- Counter update:
  - Grant to i and valid response to i in the same cycle leaves counter[i] unchanged.
  - Grant and response to different requesters update both counters.
  - A counter never exceeds MAX_OUTSTANDING. Width is clog2(MAX_OUTSTANDING+1).
- Enable:
  - enabled low stops all grants; responses still decrement counters.
  - Deassertion never cancels a command already registered on command_out.
- alfull is sampled in the grant cycle. Downstream alfull margin must cover 1 registered cycle.
- outstanding_total_out and idle_out are registered, updated one cycle after the counters.

Decomposition:
- CU_PKG gains:
  - READ_ARB_NUM_REQUESTERS and READ_ARB_MAX_OUTSTANDING constants.
  - rr_next_index function, computing the round-robin search from a pointer.
- One sub-module, cu_round_robin_arbiter (request vector, pointer -> one-hot grant, grant index, any_grant). It is reusable for the write path.
- Counter array and response routing stay in the top module.

Test Plan:
- Single requester: command_in[0].valid held 3 cycles, buffer not alfull -> 3 handshakes; command_out.valid one cycle after each; counter[0]=3; outstanding_total_out=3 one cycle later.
- All 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; never two ready bits high.
- Throttle: MAX_OUTSTANDING=16, requester 1 given 16 grants with no responses -> ready_out[1]=0 while valid. A response with cu_id=CU_ID_BASE+1 makes counter=15; requester 1 is granted on the next eligible cycle.
- alfull=1 for 5 cycles with all valid -> no grants, command_out.valid=0. On alfull=0, the grant resumes at the held rr_pointer.
- Same-cycle grant and response for requester 2 with counter=5 -> counter stays 5.
- Response with cu_id=CU_ID_BASE+7 (out of range) or to a requester with zero count -> response_error_out=1 sticky, counters unchanged. rst=1 mid-traffic -> all outputs at reset values next cycle; idle_out=1.

Source files
------------

// File: rtl/cu_read_command_arbiter_pkg.sv
// Shared types and helpers for the CU read command arbiter and its round-robin core.
// The command, response and buffer-status line formats are shared with the other CU engines.
package cu_read_command_arbiter_pkg;

  localparam int CU_ID_W = 8;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 8;

  localparam int DATA_READ_CONTROL_ID = 8;

  localparam int READ_ARB_NUM_REQUESTERS  = 4;
  localparam int READ_ARB_MAX_OUTSTANDING = 16;

  // Widest requester set the round-robin helper supports.
  localparam int RR_MAX_REQUESTERS = 8;
  localparam int RR_INDEX_W        = 3;

  typedef struct packed {
    logic [CU_ID_W-1:0] cu_id;
    logic [ADDR_W-1:0]  address;
    logic [TAG_W-1:0]   tag;
  } CommandPayload;

  typedef struct packed {
    logic          valid;
    CommandPayload cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic          valid;
    CommandPayload cmd;
  } ResponseBufferLine;

  typedef struct packed {
    logic empty;
    logic full;
    logic alfull;
  } BufferStatus;

  // First set request at or after pointer, wrapping at num; returns pointer when none is set.
  function automatic logic [RR_INDEX_W-1:0] rr_next_index(
    input logic [RR_MAX_REQUESTERS-1:0] request,
    input logic [RR_INDEX_W-1:0]        pointer,
    input int                           num
  );
    logic [RR_INDEX_W-1:0] result;
    logic                  found;
    int                    idx;
    result = pointer;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < RR_MAX_REQUESTERS; k++) begin
      if (k < num) begin
        idx = int'(pointer) + k;
        if (idx >= num) idx = idx - num;
        if (!found && request[idx[RR_INDEX_W-1:0]]) begin
          found  = 1'b1;
          result = idx[RR_INDEX_W-1:0];
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cu_read_command_arbiter_if.sv
// Handshake bundle between the read engines, the arbiter and the downstream command buffer.
interface cu_read_command_arbiter_if
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = READ_ARB_NUM_REQUESTERS
);

  CommandBufferLine [NUM_REQUESTERS-1:0] command_in;
  logic [NUM_REQUESTERS-1:0]             command_ready_out;
  BufferStatus                           read_command_buffer_status;
  ResponseBufferLine                     read_response_in;
  CommandBufferLine                      command_out;

  modport master (
    output command_in,
    output read_command_buffer_status,
    output read_response_in,
    input  command_ready_out,
    input  command_out
  );

  modport slave (
    input  command_in,
    input  read_command_buffer_status,
    input  read_response_in,
    output command_ready_out,
    output command_out
  );

endinterface

// File: rtl/cu_read_command_arbiter_arb.sv
// Generic round-robin picker: one-hot grant of the first request at or after pointer.
// Kept free of command types so the write path can reuse it.
module cu_round_robin_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]         request,
  input  logic [$clog2(NUM_REQUESTERS)-1:0] pointer,
  output logic [NUM_REQUESTERS-1:0]         grant,
  output logic [$clog2(NUM_REQUESTERS)-1:0] grant_index,
  output logic                              any_grant
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);

  logic [RR_MAX_REQUESTERS-1:0] request_wide;
  logic [RR_INDEX_W-1:0]        next_index;

  always_comb begin
    request_wide                      = '0;
    request_wide[NUM_REQUESTERS-1:0]  = request;
    next_index  = rr_next_index(request_wide, RR_INDEX_W'(pointer), NUM_REQUESTERS);
    any_grant   = |request;
    grant_index = IDX_W'(next_index);
    grant       = '0;
    if (any_grant) grant[grant_index] = 1'b1;
  end

endmodule

// File: rtl/cu_read_command_arbiter.sv
// Round-robin sharing of the read command buffer among the CU read engines, with a
// per-engine outstanding-read limit released by read responses.
module cu_read_command_arbiter
  import cu_read_command_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS  = READ_ARB_NUM_REQUESTERS,
  parameter int MAX_OUTSTANDING = READ_ARB_MAX_OUTSTANDING,
  parameter int CU_ID_BASE      = DATA_READ_CONTROL_ID,
  localparam int TOTAL_W        = $clog2(NUM_REQUESTERS * MAX_OUTSTANDING + 1)
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        enabled_in,
  cu_read_command_arbiter_if.slave    bus,
  output logic [TOTAL_W-1:0]          outstanding_total_out,
  output logic                        idle_out,
  output logic                        response_error_out
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CU_ID_W-1:0] ID_BASE  = CU_ID_W'(CU_ID_BASE);
  localparam logic [CU_ID_W-1:0] ID_COUNT = CU_ID_W'(NUM_REQUESTERS);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQUESTERS - 1);

  logic                      enabled;
  logic [IDX_W-1:0]          rr_pointer;
  logic [CNT_W-1:0]          counter [NUM_REQUESTERS];
  CommandBufferLine          command_q;
  CommandBufferLine          command_next;

  logic [NUM_REQUESTERS-1:0] request;
  logic [NUM_REQUESTERS-1:0] grant;
  logic [IDX_W-1:0]          grant_index;
  logic [IDX_W-1:0]          next_pointer;
  logic                      any_grant;

  logic [CU_ID_W-1:0]        resp_offset;
  logic                      resp_in_range;
  logic [IDX_W-1:0]          resp_index;
  logic [NUM_REQUESTERS-1:0] resp_hit;
  logic                      resp_error;

  logic [TOTAL_W-1:0]        counter_sum;
  logic                      counters_zero;
  logic                      unused_status_bits;

  assign unused_status_bits = ^{bus.read_command_buffer_status.empty,
                                bus.read_command_buffer_status.full,
                                bus.read_response_in.cmd.address,
                                bus.read_response_in.cmd.tag};

  // alfull is sampled in the grant cycle, so downstream reserves one slot for command_q.
  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      request[i] = bus.command_in[i].valid && (counter[i] < CNT_MAX) && enabled &&
                   !bus.read_command_buffer_status.alfull;
    end
  end

  cu_round_robin_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_rr (
    .request     (request),
    .pointer     (rr_pointer),
    .grant       (grant),
    .grant_index (grant_index),
    .any_grant   (any_grant)
  );

  assign bus.command_ready_out = grant;
  assign bus.command_out       = command_q;

  always_comb begin
    next_pointer = (grant_index == IDX_LAST) ? '0 : grant_index + 1'b1;
    command_next = '0;
    if (any_grant) begin
      command_next       = bus.command_in[grant_index];
      command_next.valid = 1'b1;
    end
  end

  // Responses for an unknown cu_id or an idle requester are flagged and otherwise ignored.
  always_comb begin
    resp_offset   = bus.read_response_in.cmd.cu_id - ID_BASE;
    resp_in_range = (bus.read_response_in.cmd.cu_id >= ID_BASE) && (resp_offset < ID_COUNT);
    resp_index    = resp_offset[IDX_W-1:0];
    resp_hit      = '0;
    resp_error    = 1'b0;
    if (bus.read_response_in.valid) begin
      if (resp_in_range && (counter[resp_index] != '0)) begin
        resp_hit[resp_index] = 1'b1;
      end else begin
        resp_error = 1'b1;
      end
    end
  end

  always_comb begin
    counter_sum   = '0;
    counters_zero = 1'b1;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      counter_sum = counter_sum + TOTAL_W'(counter[i]);
      if (counter[i] != '0) counters_zero = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      enabled    <= 1'b0;
      rr_pointer <= '0;
      command_q  <= '0;
      for (int i = 0; i < NUM_REQUESTERS; i++) counter[i] <= '0;
    end else begin
      enabled   <= enabled_in;
      command_q <= command_next;
      if (any_grant) rr_pointer <= next_pointer;
      // A grant and a response to the same requester cancel out.
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        case ({grant[i], resp_hit[i]})
          2'b10:   counter[i] <= counter[i] + 1'b1;
          2'b01:   counter[i] <= counter[i] - 1'b1;
          default: counter[i] <= counter[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      outstanding_total_out <= '0;
      idle_out              <= 1'b1;
      response_error_out    <= 1'b0;
    end else begin
      outstanding_total_out <= counter_sum;
      idle_out              <= counters_zero && !command_q.valid;
      if (resp_error) response_error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cu_read_command_arbiter.sv
// Self-checking bench: fixed vector table, directed corner sequences and random traffic
// compared against a cycle-level model of the arbitration and counting rules.
module tb_cu_read_command_arbiter;
  import cu_read_command_arbiter_pkg::*;

  localparam int N       = 4;
  localparam int MAX     = 16;
  localparam int BASE    = DATA_READ_CONTROL_ID;
  localparam int TOTAL_W = $clog2(N * MAX + 1);

  logic               clock = 1'b0;
  logic               rst;
  logic               enabled_in;
  logic [TOTAL_W-1:0] outstanding_total_out;
  logic               idle_out;
  logic               response_error_out;

  int       vectors     = 0;
  int       miscompares = 0;
  bit [7:0] tag_seq     = 8'd0;

  int               m_cnt [N];
  int               m_ptr;
  bit               m_en;
  CommandBufferLine m_cmd;
  int               m_total;
  bit               m_idle;
  bit               m_err;

  typedef struct {
    logic [N-1:0] valid;
    logic         alfull;
    logic [N-1:0] exp_ready;
    logic         exp_cmd_valid;
    int           exp_total;
  } vector_t;

  vector_t table_vec [20];

  always #5 clock = ~clock;

  cu_read_command_arbiter_if #(.NUM_REQUESTERS(N)) bus ();

  cu_read_command_arbiter #(
    .NUM_REQUESTERS  (N),
    .MAX_OUTSTANDING (MAX),
    .CU_ID_BASE      (BASE)
  ) dut (
    .clock                 (clock),
    .rst                   (rst),
    .enabled_in            (enabled_in),
    .bus                   (bus),
    .outstanding_total_out (outstanding_total_out),
    .idle_out              (idle_out),
    .response_error_out    (response_error_out)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid_mask, input logic alfull,
                               input logic resp_valid, input int resp_slot);
    for (int i = 0; i < N; i++) begin
      bus.command_in[i].valid       = valid_mask[i];
      bus.command_in[i].cmd.cu_id   = CU_ID_W'(BASE + i);
      bus.command_in[i].cmd.address = $urandom;
      bus.command_in[i].cmd.tag     = tag_seq;
      tag_seq++;
    end
    bus.read_command_buffer_status.empty  = 1'b0;
    bus.read_command_buffer_status.full   = 1'b0;
    bus.read_command_buffer_status.alfull = alfull;
    bus.read_response_in           = '0;
    bus.read_response_in.valid     = resp_valid;
    bus.read_response_in.cmd.cu_id = CU_ID_W'(BASE + resp_slot);
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr   = 0;
    m_en    = 1'b0;
    m_cmd   = '0;
    m_total = 0;
    m_idle  = 1'b1;
    m_err   = 1'b0;
  endtask

  // One clock: compare against the model mid-cycle, then advance the model at the edge.
  task automatic tick();
    int               g;
    int               idx;
    int               sum;
    int               n_cnt [N];
    bit               all_zero;
    logic [N-1:0]     exp_ready;
    CommandBufferLine n_cmd;
    @(negedge clock);
    g = -1;
    if (m_en && !bus.read_command_buffer_status.alfull) begin
      for (int off = 0; off < N; off++) begin
        int i;
        i = (m_ptr + off) % N;
        if (g < 0 && bus.command_in[i].valid && m_cnt[i] < MAX) g = i;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("ready", bus.command_ready_out, exp_ready);
    checkOutput("command_out", bus.command_out, m_cmd);
    checkOutput("total", outstanding_total_out, m_total);
    checkOutput("idle", idle_out, m_idle);
    checkOutput("error", response_error_out, m_err);
    sum = 0;
    all_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_cnt[i] = m_cnt[i];
      sum += m_cnt[i];
      if (m_cnt[i] != 0) all_zero = 1'b0;
    end
    n_cmd = '0;
    if (g >= 0) begin
      n_cmd       = bus.command_in[g];
      n_cmd.valid = 1'b1;
      n_cnt[g]++;
    end
    if (bus.read_response_in.valid) begin
      idx = int'(bus.read_response_in.cmd.cu_id) - BASE;
      if (idx >= 0 && idx < N && m_cnt[idx] > 0) n_cnt[idx]--;
      else m_err = 1'b1;
    end
    @(posedge clock);
    if (rst) begin
      modelReset();
    end else begin
      m_idle  = all_zero && !m_cmd.valid;
      m_total = sum;
      m_cmd   = n_cmd;
      if (g >= 0) m_ptr = (g + 1) % N;
      m_en    = enabled_in;
      for (int i = 0; i < N; i++) m_cnt[i] = n_cnt[i];
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    table_vec[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
    table_vec[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 0};
    table_vec[2]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 0};
    table_vec[3]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1};
    table_vec[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2};
    table_vec[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 3};
    table_vec[6]  = '{4'b1111, 1'b0, 4'b0010, 1'b0, 3};
    table_vec[7]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 3};
    table_vec[8]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 4};
    table_vec[9]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 5};
    table_vec[10] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 6};
    table_vec[11] = '{4'b1111, 1'b0, 4'b0100, 1'b1, 7};
    table_vec[12] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8};
    table_vec[13] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 9};
    table_vec[14] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 10};
    table_vec[15] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 11};
    table_vec[16] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 11};
    table_vec[17] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 11};
    table_vec[18] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 11};
    table_vec[19] = '{4'b1111, 1'b0, 4'b0010, 1'b0, 11};

    rst        = 1'b1;
    enabled_in = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    modelReset();

    for (int r = 0; r < 20; r++) begin
      applyStimulus(table_vec[r].valid, table_vec[r].alfull, 1'b0, 0);
      #3;
      checkOutput("tbl_ready", bus.command_ready_out, table_vec[r].exp_ready);
      checkOutput("tbl_cmd_valid", bus.command_out.valid, table_vec[r].exp_cmd_valid);
      checkOutput("tbl_total", outstanding_total_out, table_vec[r].exp_total);
      tick();
    end

    // Requester 2 climbs to 5, then a grant and a response to it land together.
    repeat (3) begin
      applyStimulus(4'b0100, 1'b0, 1'b0, 0);
      tick();
    end
    applyStimulus(4'b0100, 1'b0, 1'b1, 2);
    #3;
    checkOutput("same_cycle_ready", bus.command_ready_out, 4'b0100);
    tick();
    repeat (2) begin
      applyStimulus('0, 1'b0, 1'b0, 0);
      tick();
    end
    checkOutput("same_cycle_total", outstanding_total_out, 15);

    // Requester 1 goes from 3 to the 16-command limit and stalls until a response.
    repeat (13) begin
      applyStimulus(4'b0010, 1'b0, 1'b0, 0);
      tick();
    end
    applyStimulus(4'b0010, 1'b0, 1'b0, 0);
    #3;
    checkOutput("throttle_ready", bus.command_ready_out, 4'b0000);
    tick();
    applyStimulus(4'b0010, 1'b0, 1'b1, 1);
    #3;
    checkOutput("throttle_resp_ready", bus.command_ready_out, 4'b0000);
    tick();
    applyStimulus(4'b0010, 1'b0, 1'b0, 0);
    #3;
    checkOutput("throttle_release", bus.command_ready_out, 4'b0010);
    tick();

    applyStimulus('0, 1'b0, 1'b1, 7);
    tick();
    checkOutput("error_set", response_error_out, 1'b1);
    applyStimulus('0, 1'b0, 1'b1, 3);
    tick();
    checkOutput("error_sticky", response_error_out, 1'b1);

    for (int c = 0; c < 400; c++) begin
      int slot;
      enabled_in = ($urandom_range(0, 9) != 0);
      slot = ($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, N - 1));
      applyStimulus(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 1) == 1, slot);
      tick();
    end

    enabled_in = 1'b1;
    applyStimulus(4'b1111, 1'b0, 1'b1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_cmd_valid", bus.command_out.valid, 1'b0);
    checkOutput("reset_total", outstanding_total_out, 0);
    checkOutput("reset_error", response_error_out, 1'b0);
    checkOutput("reset_idle", idle_out, 1'b1);

    applyStimulus('0, 1'b0, 1'b1, 0);
    tick();
    checkOutput("zero_count_error", response_error_out, 1'b1);
    applyStimulus('0, 1'b0, 1'b0, 0);
    tick();
    checkOutput("zero_count_total", outstanding_total_out, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
